// File: rtl/map_stream_loader.sv
// Tile-map stream loader: assembles the 128-bit tile map from an SPI byte
// stream in a shadow register and commits it to the live map on frame start.
module map_stream_loader #(
  parameter int unsigned MAP_BITS = 128,
  parameter int unsigned TIMEOUT  = 50000
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic [7:0]          iByte,
  input  logic                iByteValid,
  output logic                oByteReady,
  input  logic                iFrameStart,
  input  logic                iClearError,
  output logic [MAP_BITS-1:0] oMap,
  output logic                oMapUpdated,
  output logic                oBusy,
  output logic [1:0]          oError
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_LOAD  = 8'hA5;
  localparam logic [7:0] CMD_TILE  = 8'h5A;
  localparam logic [7:0] CMD_CLEAR = 8'hC3;

  typedef enum logic [1:0] {
    StIdle,
    StLoadFull,
    StTileArg,
    StWaitFrame
  } state_e;

  state_e              state;
  logic [MAP_BITS-1:0] shadow;
  logic [3:0]          byte_cnt;
  logic [TW-1:0]       to_cnt;
  logic                accept;
  logic                in_payload;
  logic                timed_out;
  logic [1:0]          err_set;

  // Handshake and status decoded straight from state.
  always_comb begin
    oByteReady = (state != StWaitFrame);
    oBusy      = (state != StIdle);
    accept     = iByteValid && oByteReady;
    in_payload = (state == StLoadFull) || (state == StTileArg);
    timed_out  = in_payload && !accept && (to_cnt == TO_LAST);
    err_set    = 2'b00;
    if (state == StIdle && accept &&
        iByte != CMD_LOAD && iByte != CMD_TILE && iByte != CMD_CLEAR) begin
      err_set[0] = 1'b1;
    end
    err_set[1] = timed_out;
  end

  // Command FSM, shadow staging, timeout watchdog, commit and sticky errors.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= StIdle;
      shadow      <= '0;
      oMap        <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      oMapUpdated <= 1'b0;
      oError      <= 2'b00;
    end else begin
      oMapUpdated <= 1'b0;
      // Set-dominant: a bit being set this cycle survives a clear request.
      oError      <= (iClearError ? 2'b00 : oError) | err_set;

      // Watchdog only runs while waiting on payload bytes.
      if (!in_payload || accept || timed_out) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (accept) begin
            unique case (iByte)
              CMD_LOAD: begin
                shadow   <= '0;
                byte_cnt <= '0;
                state    <= StLoadFull;
              end
              CMD_TILE: begin
                shadow <= oMap;
                state  <= StTileArg;
              end
              CMD_CLEAR: begin
                shadow <= '0;
                state  <= StWaitFrame;
              end
              default: state <= StIdle;
            endcase
          end
        end
        StLoadFull: begin
          if (accept) begin
            shadow[8*byte_cnt +: 8] <= iByte;
            byte_cnt                <= byte_cnt + 1'b1;
            if (byte_cnt == 4'd15) begin
              state <= StWaitFrame;
            end
          end else if (timed_out) begin
            shadow   <= '0;
            byte_cnt <= '0;
            state    <= StIdle;
          end
        end
        StTileArg: begin
          if (accept) begin
            shadow[iByte[6:0]] <= iByte[7];
            state              <= StWaitFrame;
          end else if (timed_out) begin
            shadow <= '0;
            state  <= StIdle;
          end
        end
        StWaitFrame: begin
          // A pulse coincident with the final byte arrives before this state
          // is entered, so it is naturally ignored.
          if (iFrameStart) begin
            oMap        <= shadow;
            oMapUpdated <= 1'b1;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_map_stream_loader.sv
// Directed bench for map_stream_loader with hand-computed expected maps.
module tb_map_stream_loader;

  localparam int unsigned TO = 8;

  logic         iCLK = 1'b0;
  logic         iRST_n = 1'b0;
  logic [7:0]   iByte = 8'h00;
  logic         iByteValid = 1'b0;
  logic         oByteReady;
  logic         iFrameStart = 1'b0;
  logic         iClearError = 1'b0;
  logic [127:0] oMap;
  logic         oMapUpdated;
  logic         oBusy;
  logic [1:0]   oError;

  int n_cmp = 0;
  int n_err = 0;

  map_stream_loader #(
    .MAP_BITS(128),
    .TIMEOUT (TO)
  ) dut (
    .iCLK       (iCLK),
    .iRST_n     (iRST_n),
    .iByte      (iByte),
    .iByteValid (iByteValid),
    .oByteReady (oByteReady),
    .iFrameStart(iFrameStart),
    .iClearError(iClearError),
    .oMap       (oMap),
    .oMapUpdated(oMapUpdated),
    .oBusy      (oBusy),
    .oError     (oError)
  );

  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle with optional byte, frame pulse and error clear; ends #1 past the edge.
  task automatic cyc(input logic vld, input logic [7:0] b, input logic fs, input logic clr);
    iByteValid  = vld;
    iByte       = b;
    iFrameStart = fs;
    iClearError = clr;
    @(posedge iCLK);
    #1;
    iByteValid  = 1'b0;
    iFrameStart = 1'b0;
    iClearError = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic frame();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  logic [127:0] exp_map;
  int           upd_seen;

  initial begin
    // Reset state
    #12;
    iRST_n = 1'b1;
    #1;
    check_eq("rst_map", oMap, '0);
    check_eq("rst_ready", 128'(oByteReady), 128'd1);
    check_eq("rst_busy", 128'(oBusy), 128'd0);
    check_eq("rst_err", 128'(oError), 128'd0);
    check_eq("rst_upd", 128'(oMapUpdated), 128'd0);
    @(posedge iCLK);
    #1;

    // Full load: byte0 = 0x01 -> bit0, byte15 = 0x80 -> bit127
    send(8'hA5);
    check_eq("load_busy", 128'(oBusy), 128'd1);
    send(8'h01);
    for (int i = 0; i < 14; i++) send(8'h00);
    send(8'h80);
    check_eq("load_ready_low", 128'(oByteReady), 128'd0);
    upd_seen = 0;
    for (int i = 0; i < 9; i++) begin
      idle(1);
      if (oMapUpdated) upd_seen++;
      if (oByteReady) upd_seen += 100;
    end
    check_eq("load_wait_quiet", 128'(upd_seen), 128'd0);
    check_eq("load_map_held", oMap, '0);
    frame();
    exp_map = '0;
    exp_map[0] = 1'b1;
    exp_map[127] = 1'b1;
    check_eq("load_map", oMap, exp_map);
    check_eq("load_upd", 128'(oMapUpdated), 128'd1);
    idle(1);
    check_eq("load_upd_once", 128'(oMapUpdated), 128'd0);
    check_eq("load_idle", 128'(oBusy), 128'd0);

    // Tile edit: index 17 set, then index 0 cleared
    send(8'h5A);
    send(8'h91);
    frame();
    exp_map[17] = 1'b1;
    check_eq("tile_set17", oMap, exp_map);
    send(8'h5A);
    send(8'h00);
    frame();
    exp_map[0] = 1'b0;
    check_eq("tile_clr0", oMap, exp_map);

    // Frame pulse coincident with the final payload byte is ignored
    send(8'h5A);
    cyc(1'b1, 8'h85, 1'b1, 1'b0);
    check_eq("coin_map_held", oMap, exp_map);
    check_eq("coin_no_upd", 128'(oMapUpdated), 128'd0);
    check_eq("coin_busy", 128'(oBusy), 128'd1);
    frame();
    exp_map[5] = 1'b1;
    check_eq("coin_commit", oMap, exp_map);

    // Payload timeout after TO idle cycles
    send(8'hA5);
    send(8'hFF);
    send(8'hFF);
    send(8'hFF);
    idle(6);
    check_eq("to_not_yet", 128'(oError), 128'd0);
    check_eq("to_busy", 128'(oBusy), 128'd1);
    idle(2);
    check_eq("to_err", 128'(oError), 128'b10);
    check_eq("to_idle", 128'(oBusy), 128'd0);
    check_eq("to_map_held", oMap, exp_map);
    frame();
    check_eq("to_no_commit", oMap, exp_map);

    // Bad command, then clear coincident with another bad command
    send(8'h17);
    check_eq("bad_err", 128'(oError), 128'b11);
    check_eq("bad_busy", 128'(oBusy), 128'd0);
    cyc(1'b1, 8'h17, 1'b0, 1'b1);
    check_eq("bad_clr_setdom", 128'(oError), 128'b01);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("err_cleared", 128'(oError), 128'd0);

    // Clear command coincident with frame, then commit zeroes the map
    cyc(1'b1, 8'hC3, 1'b1, 1'b0);
    check_eq("c3_coin_held", oMap, exp_map);
    check_eq("c3_ready_low", 128'(oByteReady), 128'd0);
    frame();
    check_eq("c3_zero", oMap, '0);
    check_eq("c3_upd", 128'(oMapUpdated), 128'd1);

    // Reset during WAIT_FRAME drops the pending commit
    send(8'h5A);
    send(8'h83);
    frame();
    exp_map = '0;
    exp_map[3] = 1'b1;
    check_eq("pre_rst_map", oMap, exp_map);
    send(8'h5A);
    send(8'h8A);
    #2;
    iRST_n = 1'b0;
    #1;
    check_eq("rst_async_map", oMap, '0);
    check_eq("rst_async_busy", 128'(oBusy), 128'd0);
    @(posedge iCLK);
    #2;
    iRST_n = 1'b1;
    @(posedge iCLK);
    #1;
    frame();
    check_eq("rst_no_upd", 128'(oMapUpdated), 128'd0);
    check_eq("rst_map_zero", oMap, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/map_stream_loader.md
Name: map_stream_loader

Overview:
- Upstream stage of the tile-address mapper. Builds the 128-bit tile map (bit index = xtile + 16*ytile; xtile 0..15, ytile 0..7; 1 = tile type 1) from a byte stream delivered by the SPI slave.
- Stages edits in a shadow register and commits them to the live map only on a frame-start pulse, so the display never shows a half-updated map.

Parameters:
- MAP_BITS, 128, width of the map; fixed at 16 x 8 tiles.
- TIMEOUT, 50000, iCLK cycles allowed between payload bytes before a command is aborted.

Ports:
- iCLK  input  1  system clock; all logic is on the rising edge.
- iRST_n  input  1  asynchronous active-low reset.
- iByte  input  8  incoming data byte.
- iByteValid  input  1  iByte is valid this cycle.
- oByteReady  input-acceptor, output  1  block accepts a byte this cycle. A transfer occurs when iByteValid && oByteReady.
- iFrameStart  input  1  one-cycle pulse at start of vertical blank, from the MTL controller.
- iClearError  input  1  clears oError.
- oMap  output  128  live map, fed to the tile-address mapper.
- oMapUpdated  output  1  one-cycle pulse in the cycle oMap changes.
- oBusy  output  1  high in any state other than IDLE.
- oError  output  2  sticky flags. Bit0 = unknown command byte; bit1 = payload timeout.

Behaviour:
- Reset (asynchronous):
  - State IDLE; oMap = 0; shadow = 0.
  - Byte counter = 0; timeout counter = 0.
  - oMapUpdated = 0; oError = 0; oBusy = 0.
  - oByteReady = 1 once reset is released.
- oByteReady = (state != WAIT_FRAME). It is combinational from state.
- States: IDLE, LOAD_FULL, TILE_ARG, WAIT_FRAME.
- IDLE, on an accepted byte:
  - 0xA5: shadow <= 0, byte counter <= 0, go to LOAD_FULL.
  - 0x5A: shadow <= oMap, go to TILE_ARG.
  - 0xC3: shadow <= 0, go to WAIT_FRAME.
  - Any other value: set oError[0], stay in IDLE.
- LOAD_FULL:
  - Accepted byte k (0..15) writes shadow[8k+7:8k], with bit0 = lowest tile index.
  - Byte 2y therefore holds tiles x0..x7 of row y; byte 2y+1 holds x8..x15.
  - On byte 15: go to WAIT_FRAME.
- TILE_ARG:
  - Accepted byte: shadow[byte[6:0]] <= byte[7]; go to WAIT_FRAME.
- Timeout (LOAD_FULL and TILE_ARG only):
  - The timeout counter increments every cycle with no accepted byte and resets to 0 on every accepted byte.
  - When it reaches TIMEOUT-1: set oError[1], discard shadow (oMap unchanged), return to IDLE, counter <= 0.
  - Counter width is $clog2(TIMEOUT+1).
- WAIT_FRAME:
  - No bytes are accepted.
  - On iFrameStart: oMap <= shadow, oMapUpdated = 1 for exactly that cycle, go to IDLE.
- Latency: oMap updates on the first iFrameStart sampled in WAIT_FRAME, i.e. at the earliest the cycle after the last byte. A frame pulse coincident with the final payload byte is ignored; the commit waits for the next pulse.
- iFrameStart in IDLE, LOAD_FULL or TILE_ARG has no effect.
- oError:
  - Flags are set-dominant: a new error in the same cycle as iClearError still sets its bit.
  - iClearError clears only the bits not being set that cycle.
- oBusy = (state != IDLE).
- A reset mid-command discards everything, including a pending commit; oMap returns to 0.
- The byte counter wraps only via its state exit; no count beyond 15 is possible.

Test Plan:
- Full load, no gaps: 0xA5 then bytes 0x01,0x00 x14,0x80, then iFrameStart 10 cycles later → oMap = bit0 and bit127 set, others 0. oMapUpdated pulses once, exactly on the frame cycle; oByteReady is 0 between the last byte and the frame pulse.
- Tile edit on that map: 0x5A, 0x91 (index 17, value 1), frame → oMap bits 0, 17 and 127 set. Then 0x5A, 0x00, frame → bit0 cleared.
- Coincident frame: last byte of a 0xC3 command (or byte 15 of a load) in the same cycle as iFrameStart → oMap unchanged that cycle; commit happens on the next iFrameStart.
- Timeout (TIMEOUT=8 in bench): 0xA5, 3 bytes, then idle → oError = 2'b10 after 8 cycles, state IDLE, oMap unchanged. A later 0xC3 + frame zeroes oMap.
- Bad command 0x17 in IDLE → oError[0] = 1, oBusy stays 0. iClearError asserted in the same cycle as a second 0x17 → oError[0] remains 1.
- Reset asserted during WAIT_FRAME → oMap = 0 immediately (asynchronous); no oMapUpdated pulse on the next iFrameStart.
